// File: rtl/snake_tick_scheduler_if.sv
// Handshake bundle between the tick scheduler, the PmodJSTK SPI
// controller and the game-state FSM.
interface snake_tick_scheduler_if;
   logic       EN;
   logic [3:0] LEVEL;
   logic       SPI_BUSY;
   logic       MOVE_ACK;
   logic       CLR_OVR;
   logic       SPI_START;
   logic       MOVE_REQ;
   logic [7:0] OVR_CNT;
   logic       BUSY;

   modport master (
      output EN, LEVEL, SPI_BUSY, MOVE_ACK, CLR_OVR,
      input  SPI_START, MOVE_REQ, OVR_CNT, BUSY
   );

   modport slave (
      input  EN, LEVEL, SPI_BUSY, MOVE_ACK, CLR_OVR,
      output SPI_START, MOVE_REQ, OVR_CNT, BUSY
   );
endinterface

// File: rtl/snake_tick_scheduler.sv
// Snake game tick scheduler: joystick poll and move-step enables,
// every move preceded by a fresh SPI joystick sample.
module snake_tick_scheduler #(
   parameter int POLL_PERIOD      = 20_000_000,
   parameter int BASE_MOVE_PERIOD = 25_000_000,
   parameter int STEP_PERIOD      = 2_000_000,
   parameter int MIN_MOVE_PERIOD  = 5_000_000,
   parameter int BUSY_TIMEOUT     = 16,
   parameter int CW               = 25
) (
   input logic                   CLK,
   input logic                   RESETN,
   snake_tick_scheduler_if.slave bus
);

   localparam int PW = CW + 4;
   localparam int TW = $clog2(BUSY_TIMEOUT) + 1;
   localparam logic [PW-1:0] BASE_P = PW'(BASE_MOVE_PERIOD);
   localparam logic [PW-1:0] MIN_P  = PW'(MIN_MOVE_PERIOD);
   localparam logic [PW-1:0] SPAN_P = BASE_P - MIN_P;
   localparam logic [CW-1:0] POLL_RELOAD = CW'(POLL_PERIOD - 1);
   localparam logic [CW-1:0] MOVE_INIT   = CW'(BASE_MOVE_PERIOD - 1);
   localparam logic [TW-1:0] TMO_LAST    = TW'(BUSY_TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE, START, WAIT_HI, WAIT_LO, MOVE
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] poll_cnt_q, poll_cnt_d;
   logic [CW-1:0] move_cnt_q, move_cnt_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic          mv_q, mv_d;
   logic          move_pend_q, move_pend_d;
   logic          poll_pend_q, poll_pend_d;
   logic [7:0]    ovr_q, ovr_d;
   logic          spi_start_q, spi_start_d;
   logic          move_req_q, move_req_d;
   logic          busy_q, busy_d;

   logic [PW-1:0] lvl_prod;
   logic [PW-1:0] move_period;
   logic [CW-1:0] move_reload;
   logic          poll_exp;
   logic          move_exp;
   logic          go;

   // Clamp before subtracting so the period never wraps below the floor
   always_comb begin
      lvl_prod    = PW'(bus.LEVEL) * PW'(STEP_PERIOD);
      move_period = (lvl_prod >= SPAN_P) ? MIN_P : BASE_P - lvl_prod;
      move_reload = CW'(move_period - PW'(1));
   end

   always_comb begin
      poll_exp   = bus.EN && (poll_cnt_q == '0);
      move_exp   = bus.EN && (move_cnt_q == '0);
      poll_cnt_d = poll_cnt_q;
      move_cnt_d = move_cnt_q;
      if (bus.EN) begin
         poll_cnt_d = poll_exp ? POLL_RELOAD : poll_cnt_q - 1'b1;
         move_cnt_d = move_exp ? move_reload : move_cnt_q - 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      mv_d    = mv_q;
      tmr_d   = '0;
      go      = (state_q == IDLE) && bus.EN &&
                (move_pend_q || poll_pend_q);
      unique case (state_q)
         IDLE: begin
            if (go) begin
               state_d = START;
               mv_d    = move_pend_q;
            end
         end
         START: state_d = WAIT_HI;
         WAIT_HI: begin
            if (bus.SPI_BUSY) begin
               state_d = WAIT_LO;
            end else if (tmr_q == TMO_LAST) begin
               state_d = mv_q ? MOVE : IDLE;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         WAIT_LO: begin
            if (!bus.SPI_BUSY) state_d = mv_q ? MOVE : IDLE;
         end
         MOVE: begin
            if (bus.MOVE_ACK) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // One poll serves both: launching any sequence consumes poll_pend
   always_comb begin
      move_pend_d = move_pend_q;
      poll_pend_d = poll_pend_q;
      ovr_d       = ovr_q;
      if (go && move_pend_q) move_pend_d = 1'b0;
      if (move_exp) move_pend_d = 1'b1;
      if (poll_exp && state_q == IDLE) poll_pend_d = 1'b1;
      if (go) poll_pend_d = 1'b0;
      if (move_exp && move_pend_q && ovr_q != 8'hFF) ovr_d = ovr_q + 1'b1;
      if (bus.CLR_OVR) ovr_d = '0;
   end

   always_comb begin
      spi_start_d = (state_q == START);
      move_req_d  = (state_d == MOVE);
      busy_d      = (state_d != IDLE);
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state_q     <= IDLE;
         poll_cnt_q  <= POLL_RELOAD;
         move_cnt_q  <= MOVE_INIT;
         tmr_q       <= '0;
         mv_q        <= 1'b0;
         move_pend_q <= 1'b0;
         poll_pend_q <= 1'b0;
         ovr_q       <= '0;
         spi_start_q <= 1'b0;
         move_req_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         poll_cnt_q  <= poll_cnt_d;
         move_cnt_q  <= move_cnt_d;
         tmr_q       <= tmr_d;
         mv_q        <= mv_d;
         move_pend_q <= move_pend_d;
         poll_pend_q <= poll_pend_d;
         ovr_q       <= ovr_d;
         spi_start_q <= spi_start_d;
         move_req_q  <= move_req_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.SPI_START = spi_start_q;
   assign bus.MOVE_REQ  = move_req_q;
   assign bus.OVR_CNT   = ovr_q;
   assign bus.BUSY      = busy_q;

endmodule

// File: doc/snake_tick_scheduler.md
# snake_tick_scheduler

Sequences the periodic events of the Snake game from the 100 MHz board clock: joystick polls on the PmodJSTK SPI interface and snake move steps toward the game logic. It replaces free-running divided clocks with single-cycle enables in the CLK domain. Every move step is preceded by a fresh joystick sample. The block sits between the PmodJSTK SPI controller and the game-state FSM. It also owns the speed-vs-level schedule.

## Interface
- POLL_PERIOD, 20_000_000 — CLK cycles between stand-alone joystick polls (5 Hz).
- BASE_MOVE_PERIOD, 25_000_000 — move period at LEVEL=0 (4 Hz).
- STEP_PERIOD, 2_000_000 — period reduction per LEVEL increment.
- MIN_MOVE_PERIOD, 5_000_000 — floor on move period.
- BUSY_TIMEOUT, 16 — cycles to wait for SPI_BUSY to rise after SPI_START.
- CW, 25 — counter width; must hold max(POLL_PERIOD, BASE_MOVE_PERIOD).
- CLK in 1 — 100 MHz board clock; all logic on posedge.
- RESETN in 1 — asynchronous, active-low reset.
- EN in 1 — 1 = run, 0 = pause.
- LEVEL in 4 — speed level 0..15.
- SPI_BUSY in 1 — high while the SPI controller transfers.
- MOVE_ACK in 1 — game logic has consumed the move.
- CLR_OVR in 1 — synchronous clear of OVR_CNT.
- SPI_START out 1 — one-cycle pulse that starts a joystick transfer.
- MOVE_REQ out 1 — level request for a move step, held until acknowledged.
- OVR_CNT out 8 — saturating count of lost move ticks.
- BUSY out 1 — high whenever the FSM is not IDLE.

## Operation
- Move period = max(BASE_MOVE_PERIOD − LEVEL×STEP_PERIOD, MIN_MOVE_PERIOD), computed in CW+4-bit unsigned arithmetic with no wrap.
  - LEVEL is sampled only when the move counter reloads.
  - A mid-period LEVEL change takes effect from the next period.
- Two down-counters:
  - poll_cnt reloads to POLL_PERIOD−1.
  - move_cnt reloads to the move period −1.
  - Each expires when it is at 0 with EN=1; it then reloads on the same edge.
  - With EN=0 both counters hold their value.
- move_pend flag:
  - Set on a move expiry.
  - Cleared when the FSM leaves IDLE for a move sequence.
  - A move expiry while move_pend is already set increments OVR_CNT, saturating at 255.
- poll_pend flag:
  - Set on a poll expiry while the FSM is IDLE.
  - A poll expiry while the FSM is not IDLE is dropped with no other effect.
- FSM states:
  - IDLE → START when move_pend or poll_pend is set and EN=1. Move has priority. Record mv = move_pend and clear the consumed flag(s). A move sequence also clears poll_pend, since one poll serves both.
  - START: assert SPI_START for exactly one cycle, then → WAIT_HI.
  - WAIT_HI: → WAIT_LO when SPI_BUSY=1. After BUSY_TIMEOUT cycles without SPI_BUSY=1, treat the transfer as complete and go directly to the next step below.
  - WAIT_LO: on SPI_BUSY=0, → MOVE if mv=1, else → IDLE.
  - MOVE: MOVE_REQ=1. On MOVE_ACK=1, drop MOVE_REQ on the next edge and → IDLE.
- Pause (EN=0) only blocks new sequences; a sequence already in progress runs to completion.
- CLR_OVR has priority over a simultaneous overrun increment; the result is 0.

## Timing
- Reset values:
  - SPI_START=0, MOVE_REQ=0, OVR_CNT=0, BUSY=0.
  - FSM=IDLE; both pend flags cleared.
  - poll_cnt=POLL_PERIOD−1; move_cnt=BASE_MOVE_PERIOD−1.
- Reset is asynchronous: the block returns to reset values immediately, mid-sequence included; MOVE_REQ drops without waiting for MOVE_ACK.
- Expiry to SPI_START:
  - Expiry edge sets the pend flag.
  - Next edge: IDLE → START.
  - SPI_START is high during the cycle after that, i.e. 2 cycles after the expiry edge.
- MOVE_REQ rises on the cycle after SPI_BUSY is sampled low in WAIT_LO.
- All outputs are registered; there is no combinational path from inputs to outputs.
- First poll after reset comes POLL_PERIOD cycles later; first move comes BASE_MOVE_PERIOD cycles later (for LEVEL=0).

## Test plan
All scenarios use POLL_PERIOD=20, BASE_MOVE_PERIOD=40, STEP_PERIOD=8, MIN_MOVE_PERIOD=16, BUSY_TIMEOUT=4, and an SPI model giving 5 cycles of busy.

- Free run: LEVEL=0, EN=1, MOVE_ACK one cycle after MOVE_REQ → SPI_START pulses every 20 cycles, one MOVE_REQ every 40 cycles, each move preceded by its own SPI_START; OVR_CNT stays 0.
- Level schedule: LEVEL=2 → move period 24; LEVEL=5 → period clamps to 16; a LEVEL change mid-period alters only the following period.
- Overrun: MOVE_ACK tied low for 100 cycles → MOVE_REQ held, OVR_CNT counts each lost tick; release ACK then pulse CLR_OVR → OVR_CNT=0.
- Timeout: SPI_BUSY never rises → after 4 cycles in WAIT_HI the sequence proceeds and MOVE_REQ asserts on a move sequence.
- Pause: EN=0 during WAIT_LO → sequence completes with one MOVE_REQ, no further SPI_START, counters frozen; EN=1 resumes from the frozen counts.
- Async reset: RESETN low while MOVE_REQ=1 → MOVE_REQ=0 and OVR_CNT=0 before the next CLK edge; first SPI_START comes 20+2 cycles after release.
